// File: rtl/seven_segment_pkg.sv
// Shared types, glyph constants and the BCD-to-segment lookup for the
// seven-segment value encoder.
package seven_segment_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } encoder_state_t;

   localparam int unsigned BCD_WIDTH         = 32'd16;
   localparam int unsigned MAX_DISPLAY_VALUE = 32'd9999;

   // Segment bit0 = a .. bit6 = g, active high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] bcd_to_segments(input logic [3:0] nibble);
      logic [6:0] seg_s;
      case (nibble)
         4'd0:    seg_s = SEG_0;
         4'd1:    seg_s = SEG_1;
         4'd2:    seg_s = SEG_2;
         4'd3:    seg_s = SEG_3;
         4'd4:    seg_s = SEG_4;
         4'd5:    seg_s = SEG_5;
         4'd6:    seg_s = SEG_6;
         4'd7:    seg_s = SEG_7;
         4'd8:    seg_s = SEG_8;
         4'd9:    seg_s = SEG_9;
         default: seg_s = SEG_BLANK;
      endcase
      return seg_s;
   endfunction

endpackage

// File: rtl/binary_to_bcd_iterative.sv
// Iterative double-dabble converter: one shift-and-correct step per step_en.
// done flags the cycle in which the final step is being taken.
module binary_to_bcd_iterative
   import seven_segment_pkg::*;
#(
   parameter int VALUE_WIDTH = 14
) (
   input  logic                   clk,
   input  logic                   async_rst_n,
   input  logic                   start,
   input  logic                   step_en,
   input  logic [VALUE_WIDTH-1:0] value,
   output logic                   done,
   output logic [BCD_WIDTH-1:0]   bcd
);

   logic [VALUE_WIDTH-1:0] shift_r;
   logic [BCD_WIDTH-1:0]   bcd_r;
   logic [BCD_WIDTH-1:0]   corrected_s;
   logic [3:0]             iter_r;

   // Add-3 correction of every nibble that would overflow decimal on the shift
   always_comb begin
      corrected_s = bcd_r;
      for (int k = 0; k < 4; k++) begin
         if (bcd_r[4*k +: 4] >= 4'd5) begin
            corrected_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
         end else begin
            corrected_s[4*k +: 4] = bcd_r[4*k +: 4];
         end
      end
   end

   // Shift register, BCD accumulator and step counter
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         shift_r <= '0;
         bcd_r   <= 16'd0;
         iter_r  <= 4'd0;
      end else if (start) begin
         shift_r <= value;
         bcd_r   <= 16'd0;
         iter_r  <= 4'd0;
      end else if (step_en) begin
         bcd_r   <= (corrected_s << 1) | {15'd0, shift_r[VALUE_WIDTH-1]};
         shift_r <= shift_r << 1;
         iter_r  <= iter_r + 4'd1;
      end else begin
         shift_r <= shift_r;
         bcd_r   <= bcd_r;
         iter_r  <= iter_r;
      end
   end

   assign done = step_en && (iter_r == 4'(VALUE_WIDTH - 1));
   assign bcd  = bcd_r;

endmodule

// File: rtl/seven_segment_value_encoder.sv
// Converts a binary count into four registered 7-segment glyphs; values
// above 9999 show dashes and leading zeros are optionally blanked.
module seven_segment_value_encoder
   import seven_segment_pkg::*;
#(
   parameter int VALUE_WIDTH         = 14,
   parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
   input  logic                   clk,
   input  logic                   async_rst_n,
   input  logic                   clk_en,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   value_valid,
   output logic                   value_ready,
   output logic [6:0]             digit_0,
   output logic [6:0]             digit_1,
   output logic [6:0]             digit_2,
   output logic [6:0]             digit_3,
   output logic                   update_done
);

   encoder_state_t       state_r;
   logic                 overflow_r;
   logic                 update_done_r;
   logic [6:0]           digit_0_r, digit_1_r, digit_2_r, digit_3_r;
   logic [6:0]           glyph_0_s, glyph_1_s, glyph_2_s, glyph_3_s;
   logic [BCD_WIDTH-1:0] bcd_s;
   logic                 overflow_s;
   logic                 accept_s;
   logic                 start_s;
   logic                 step_en_s;
   logic                 conv_done_s;

   assign overflow_s = 32'(value) > MAX_DISPLAY_VALUE;
   assign accept_s   = clk_en && value_valid && (state_r == IDLE);
   assign start_s    = accept_s && !overflow_s;
   assign step_en_s  = clk_en && (state_r == CONVERT);

   binary_to_bcd_iterative #(
      .VALUE_WIDTH (VALUE_WIDTH)
   ) u_bcd (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .start       (start_s),
      .step_en     (step_en_s),
      .value       (value),
      .done        (conv_done_s),
      .bcd         (bcd_s)
   );

   // Glyph selection with dash override and leading-zero blanking
   always_comb begin
      glyph_0_s = bcd_to_segments(bcd_s[3:0]);
      glyph_1_s = bcd_to_segments(bcd_s[7:4]);
      glyph_2_s = bcd_to_segments(bcd_s[11:8]);
      glyph_3_s = bcd_to_segments(bcd_s[15:12]);
      if (overflow_r) begin
         glyph_0_s = SEG_DASH;
         glyph_1_s = SEG_DASH;
         glyph_2_s = SEG_DASH;
         glyph_3_s = SEG_DASH;
      end else if (BLANK_LEADING_ZEROS) begin
         if (bcd_s[15:12] == 4'd0) begin
            glyph_3_s = SEG_BLANK;
         end else begin
            glyph_3_s = bcd_to_segments(bcd_s[15:12]);
         end
         if (bcd_s[15:8] == 8'd0) begin
            glyph_2_s = SEG_BLANK;
         end else begin
            glyph_2_s = bcd_to_segments(bcd_s[11:8]);
         end
         if (bcd_s[15:4] == 12'd0) begin
            glyph_1_s = SEG_BLANK;
         end else begin
            glyph_1_s = bcd_to_segments(bcd_s[7:4]);
         end
      end else begin
         glyph_3_s = bcd_to_segments(bcd_s[15:12]);
      end
   end

   // Control FSM and output registers; update_done clears regardless of clk_en
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_r       <= IDLE;
         overflow_r    <= 1'b0;
         update_done_r <= 1'b0;
         digit_0_r     <= SEG_BLANK;
         digit_1_r     <= SEG_BLANK;
         digit_2_r     <= SEG_BLANK;
         digit_3_r     <= SEG_BLANK;
      end else begin
         update_done_r <= 1'b0;
         if (clk_en) begin
            case (state_r)
               IDLE: begin
                  if (value_valid) begin
                     overflow_r <= overflow_s;
                     state_r    <= overflow_s ? COMMIT : CONVERT;
                  end
               end
               CONVERT: begin
                  if (conv_done_s) begin
                     state_r <= COMMIT;
                  end
               end
               COMMIT: begin
                  digit_0_r     <= glyph_0_s;
                  digit_1_r     <= glyph_1_s;
                  digit_2_r     <= glyph_2_s;
                  digit_3_r     <= glyph_3_s;
                  update_done_r <= 1'b1;
                  state_r       <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign value_ready = (state_r == IDLE);
   assign digit_0     = digit_0_r;
   assign digit_1     = digit_1_r;
   assign digit_2     = digit_2_r;
   assign digit_3     = digit_3_r;
   assign update_done = update_done_r;

endmodule
